wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute stage.
- Registers the execute-to-writeback bundle and performs register-file writes.
- Drives the 70-bit writeback bypass bus back into execute, reports exceptions to the CSR unit through a level/ack handshake, and keeps a retired-instruction counter.
- Single-issue, in-order, one entry deep.

Parameters:
WB_W, 421, width of the execute-to-writeback bundle
CNT_W, 64, width of the retired-instruction counter

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
from_exe_i  in  WB_W  execute bundle; fields: [420] valid, [419:356] pc, [279:275] rd, [274:211] result, [143:80] xcpt cause, [79:16] xcpt tval, [15] xcpt valid, [13] regfile write enable
exe_stall_i  in  1  execute stall; bundle not final this cycle
kill_i  in  1  pipeline flush
csr_xcpt_ack_i  in  1  CSR unit accepted the exception
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  5  register-file write address
rf_wdata_o  out  64  register-file write data
wb_bypass_o  out  70  {[69] valid, [68:64] rd, [63:0] data} to execute
xcpt_valid_o  out  1  exception pending toward CSR unit
xcpt_cause_o  out  64  exception cause
xcpt_tval_o  out  64  exception tval
xcpt_pc_o  out  64  pc of the faulting instruction
flush_req_o  out  1  requests upstream squash while an exception is pending
retire_o  out  1  one-cycle pulse per retired instruction
instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rstn_i=0): internal entry invalid, state RUN, instret_o=0. All outputs 0.
- Capture, every rising edge in RUN:
  - kill_i=1 -> entry invalidated (kill has priority over everything).
  - else exe_stall_i=1 -> entry captured as bubble (valid=0); no partial multi-cycle result ever reaches WB.
  - else entry <= from_exe_i.
- Latency: an instruction occupies WB exactly one cycle; all outputs are combinational from the registered entry.
- Commit conditions for a valid entry in RUN:
  - entry xcpt=0 and regfile_we=1 and rd!=0 -> rf_we_o=1, waddr=rd, wdata=result.
  - rd=0 -> rf_we_o=0.
- wb_bypass_o: bit 69 = rf_we_o, [68:64] = rd, [63:0] = result; all zero when rf_we_o=0.
- Retire:
  - retire_o=1 for a valid, non-excepting entry in RUN, regardless of regfile_we.
  - instret_o increments by 1 on the following edge.
  - Wraps from all-ones to 0.
- State machine RUN / XCPT:
  - RUN -> XCPT: at the edge after a valid entry with xcpt=1 sits in WB. In that cycle: rf_we_o=0, retire_o=0, xcpt_valid_o=1, and cause/tval/pc are driven from the entry.
  - In XCPT:
    - Exception fields are held in a dedicated latch; xcpt_valid_o=1 and flush_req_o=1.
    - Incoming bundles are captured as bubbles; rf_we_o=0, retire_o=0.
    - kill_i does not clear the latch.
  - XCPT -> RUN on csr_xcpt_ack_i=1.
    - xcpt_valid_o and flush_req_o drop on that edge.
    - The next capture follows the RUN rules.
  - csr_xcpt_ack_i in RUN is ignored.
  - Ack in the same cycle the exception first appears in WB (still in RUN) -> accepted. The block goes directly to RUN with no XCPT cycle.
- Simultaneous events:
  - kill_i with an excepting entry already in WB: the exception in WB still signals; only the incoming entry is dropped.
  - Reset mid-XCPT: returns to RUN and clears the latch immediately.

Test Plan:
- Back-to-back ALU ops with rd=5 result 0x1234 then rd=6 result 0xABCD, no stall -> rf_we_o high two consecutive cycles with matching addr/data; wb_bypass_o=0x1_05_...1234 then 0x1_06_...ABCD; instret_o 0->2.
- Valid op with rd=0, regfile_we=1 -> rf_we_o=0, bypass valid=0, retire_o=1.
- exe_stall_i held 3 cycles over a MUL, then result 0x42 to rd=7 -> exactly one write, after stall drops; no writes or retires during the stall.
- Load with xcpt=1, cause 0x5, tval 0x8000_0003, pc 0x1000 -> xcpt_valid_o=1 with those values, no write/retire. The following 2 valid ALU bundles are dropped. Ack on 3rd cycle -> RUN; the next ALU op writes.
- kill_i asserted with a valid bundle at input -> next cycle no write, no retire. Separately: assert rstn_i=0 during XCPT -> xcpt_valid_o=0 and instret_o=0 immediately, without a clock edge.
- Preload instret_o to all-ones through a long run, then retire one instruction -> instret_o=0 (wrap).

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: registers the execute bundle, commits register-file writes,
// drives the bypass bus, reports exceptions to the CSR unit and counts retirements.
module wb_stage #(
    parameter int WB_W  = 421,
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WB_W-1:0]  from_exe_i,
    input  logic             exe_stall_i,
    input  logic             kill_i,
    input  logic             csr_xcpt_ack_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [63:0]      rf_wdata_o,
    output logic [69:0]      wb_bypass_o,
    output logic             xcpt_valid_o,
    output logic [63:0]      xcpt_cause_o,
    output logic [63:0]      xcpt_tval_o,
    output logic [63:0]      xcpt_pc_o,
    output logic             flush_req_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_XCPT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WB_W-1:0]   entry_r;
    logic [63:0]       lat_cause_r;
    logic [63:0]       lat_tval_r;
    logic [63:0]       lat_pc_r;
    logic [CNT_W-1:0]  instret_r;

    logic              e_valid_s;
    logic [63:0]       e_pc_s;
    logic [4:0]        e_rd_s;
    logic [63:0]       e_result_s;
    logic [63:0]       e_cause_s;
    logic [63:0]       e_tval_s;
    logic              e_xcpt_s;
    logic              e_we_s;
    logic              run_s;
    logic              commit_ok_s;
    logic              rf_we_s;
    logic              retire_s;

    // Field extraction from the registered entry
    always_comb begin
        e_valid_s  = entry_r[420];
        e_pc_s     = entry_r[419:356];
        e_rd_s     = entry_r[279:275];
        e_result_s = entry_r[274:211];
        e_cause_s  = entry_r[143:80];
        e_tval_s   = entry_r[79:16];
        e_xcpt_s   = entry_r[15];
        e_we_s     = entry_r[13];
    end

    // Next-state logic; an ack arriving alongside the exception skips XCPT entirely
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (e_valid_s && e_xcpt_s && !csr_xcpt_ack_i) begin
                    state_nxt_s = ST_XCPT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_XCPT: begin
                if (csr_xcpt_ack_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_XCPT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Output decode from the registered entry, state and exception latch
    always_comb begin
        run_s        = (state_r == ST_RUN);
        commit_ok_s  = run_s && e_valid_s && !e_xcpt_s;
        rf_we_s      = commit_ok_s && e_we_s && (e_rd_s != 5'd0);
        retire_s     = commit_ok_s;
        rf_we_o      = rf_we_s;
        rf_waddr_o   = 5'd0;
        rf_wdata_o   = 64'd0;
        wb_bypass_o  = 70'd0;
        retire_o     = retire_s;
        flush_req_o  = !run_s;
        xcpt_valid_o = 1'b0;
        xcpt_cause_o = 64'd0;
        xcpt_tval_o  = 64'd0;
        xcpt_pc_o    = 64'd0;
        instret_o    = instret_r;
        if (rf_we_s) begin
            rf_waddr_o  = e_rd_s;
            rf_wdata_o  = e_result_s;
            wb_bypass_o = {1'b1, e_rd_s, e_result_s};
        end else begin
            wb_bypass_o = 70'd0;
        end
        if (!run_s) begin
            xcpt_valid_o = 1'b1;
            xcpt_cause_o = lat_cause_r;
            xcpt_tval_o  = lat_tval_r;
            xcpt_pc_o    = lat_pc_r;
        end else if (e_valid_s && e_xcpt_s) begin
            xcpt_valid_o = 1'b1;
            xcpt_cause_o = e_cause_s;
            xcpt_tval_o  = e_tval_s;
            xcpt_pc_o    = e_pc_s;
        end else begin
            xcpt_valid_o = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Entry capture: kill, stall and a pending exception all load a bubble
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            entry_r <= {WB_W{1'b0}};
        end else if (kill_i || exe_stall_i || (state_r == ST_XCPT)) begin
            entry_r <= {WB_W{1'b0}};
        end else begin
            entry_r <= from_exe_i;
        end
    end

    // Exception latch loads on the RUN->XCPT transition and holds through kill
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lat_cause_r <= 64'd0;
            lat_tval_r  <= 64'd0;
            lat_pc_r    <= 64'd0;
        end else if ((state_r == ST_RUN) && (state_nxt_s == ST_XCPT)) begin
            lat_cause_r <= e_cause_s;
            lat_tval_r  <= e_tval_s;
            lat_pc_r    <= e_pc_s;
        end else begin
            lat_cause_r <= lat_cause_r;
            lat_tval_r  <= lat_tval_r;
            lat_pc_r    <= lat_pc_r;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

endmodule
